// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: decoded opcode classes, fetch
// buffer entry, controller state, and the destination-write predicate.
package issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_32      = 4'd0,
    OP_IMM_32  = 4'd1,
    LOAD       = 4'd2,
    STORE      = 4'd3,
    BRANCH     = 4'd4,
    JAL        = 4'd5,
    JALR       = 4'd6,
    LUI        = 4'd7,
    AUIPC      = 4'd8,
    MISC_MEM   = 4'd9,
    SYSTEM     = 4'd10,
    RESERVED_4 = 4'd11
  } opcode_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } issue_state_e;

  // True for opcode classes that produce a register result.
  function automatic logic writes_rd(input opcode_e op);
    case (op)
      OP_32, OP_IMM_32, LOAD, JAL, JALR, LUI, AUIPC: writes_rd = 1'b1;
      default:                                       writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Valid/ready instruction channel: used for both fetch->issue_ctrl and
// issue_ctrl->execute.
interface issue_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/idecoder.sv
// Combinational instruction decoder. Register fields an opcode does not use
// are forced to zero so the scoreboard never sees a false dependency.
module idecoder
  import issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output opcode_e     opcode,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic use_rs1_s;
  logic use_rs2_s;
  logic use_rd_s;

  // Classify the major opcode and note which register fields are live.
  always_comb begin
    opcode    = RESERVED_4;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        5'b01100: begin
          if ((instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000)) begin
            opcode = OP_32; use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1;
          end else begin
            opcode = RESERVED_4;
          end
        end
        5'b00100: begin opcode = OP_IMM_32; use_rs1_s = 1'b1; use_rd_s = 1'b1; end
        5'b00000: begin opcode = LOAD;      use_rs1_s = 1'b1; use_rd_s = 1'b1; end
        5'b01000: begin opcode = STORE;     use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
        5'b11000: begin opcode = BRANCH;    use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
        5'b11011: begin opcode = JAL;       use_rd_s  = 1'b1; end
        5'b11001: begin
          if (instr[14:12] == 3'b000) begin
            opcode = JALR; use_rs1_s = 1'b1; use_rd_s = 1'b1;
          end else begin
            opcode = RESERVED_4;
          end
        end
        5'b01101: begin opcode = LUI;       use_rd_s  = 1'b1; end
        5'b00101: begin opcode = AUIPC;     use_rd_s  = 1'b1; end
        5'b00011: begin opcode = MISC_MEM; end
        5'b11100: begin opcode = SYSTEM; end
        default:  begin opcode = RESERVED_4; end
      endcase
    end else begin
      opcode = RESERVED_4;
    end
  end

  assign rs1 = use_rs1_s ? instr[19:15] : 5'd0;
  assign rs2 = use_rs2_s ? instr[24:20] : 5'd0;
  assign rd  = use_rd_s  ? instr[11:7]  : 5'd0;

endmodule

// File: rtl/issue_ctrl_fifo.sv
// Synchronous FIFO of fetch entries. Pointers carry one extra wrap bit so
// full and empty are distinguished by their difference. An empty FIFO
// presents an all-zero head.
module issue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W:0]   wptr_r;
  logic [PTR_W:0]   rptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign count     = wptr_r - rptr_r;
  assign empty     = (count == {(PTR_W + 1){1'b0}});
  assign full      = (count == DEPTH_C);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = empty ? '0 : mem_r[rptr_r[PTR_W-1:0]];

  // Pointer update; clear empties the FIFO and discards any same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_r <= {(PTR_W + 1){1'b0}};
      rptr_r <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + ONE_C;
      if (do_pop_s)  rptr_r <= rptr_r + ONE_C;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr) mem_r[wptr_r[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched words, exposes the head to an external
// decoder, blocks on register hazards via a pending-write scoreboard, and
// halts after issuing an illegal word until the next flush.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  issue_ctrl_if.slave      fetch,
  issue_ctrl_if.master     issue,
  output logic [31:0]      dec_instr,
  input  opcode_e          dec_opcode,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  output logic             issue_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     head_s;
  fetch_entry_t     wdata_s;
  logic [PTR_W:0]   count_s;
  logic             empty_s;
  logic             full_s;
  logic             run_s;
  logic             ready_s;
  logic             push_s;
  logic             valid_s;
  logic             pop_s;
  logic             hazard_s;
  logic             stall_s;
  logic [31:0]      pend_r;
  logic [31:0]      clr_mask_s;
  logic [31:0]      set_mask_s;
  issue_state_e     state_r;
  logic [CNT_W-1:0] stall_cnt_r;

  assign run_s    = (state_r == ST_RUN);
  assign ready_s  = (count_s < DEPTH_C) && !flush && run_s;
  assign push_s   = fetch.valid && ready_s && !full_s;
  assign hazard_s = pend_r[dec_rs1] | pend_r[dec_rs2] | pend_r[dec_rd];
  assign valid_s  = !empty_s && run_s && !hazard_s && !flush;
  assign pop_s    = valid_s && issue.ready;
  assign stall_s  = !empty_s && run_s && hazard_s && !flush;

  assign wdata_s.instr = fetch.instr;
  assign wdata_s.pc    = fetch.pc;

  assign fetch.ready   = ready_s;
  assign issue.valid   = valid_s;
  assign issue.instr   = head_s.instr;
  assign issue.pc      = head_s.pc;
  assign dec_instr     = head_s.instr;
  assign issue_illegal = valid_s && (dec_opcode == RESERVED_4);
  assign halted        = (state_r == ST_HALT);
  assign stall_cnt     = stall_cnt_r;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (pop_s),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Writeback clear and issue set masks; set is applied after clear so it wins.
  always_comb begin
    clr_mask_s = 32'd0;
    set_mask_s = 32'd0;
    if (wb_valid) begin
      clr_mask_s = 32'd1 << wb_rd;
    end else begin
      clr_mask_s = 32'd0;
    end
    if (pop_s && writes_rd(dec_opcode)) begin
      set_mask_s = 32'd1 << dec_rd;
    end else begin
      set_mask_s = 32'd0;
    end
  end

  // Pending-write scoreboard; x0 never pends and flush leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 32'd0;
    end else begin
      pend_r <= ((pend_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end
  end

  // Run/halt control: an issued illegal word halts, flush always resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else if (flush) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:  state_r <= (pop_s && (dec_opcode == RESERVED_4)) ? ST_HALT : ST_RUN;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles a valid head is held back by a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl with the decoder wired to dec_* ports.
// A scoreboard records accepted fetch words and checks issued words in order.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] dec_instr;
  opcode_e     dec_opcode;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        issue_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] stall_cnt;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;
  exp_t sb_q[$];

  issue_ctrl_if fif ();
  issue_ctrl_if iif ();

  issue_ctrl #(.DEPTH(4), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch         (fif.slave),
    .issue         (iif.master),
    .dec_instr     (dec_instr),
    .dec_opcode    (dec_opcode),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .issue_illegal (issue_illegal),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .stall_cnt     (stall_cnt),
    .halted        (halted)
  );

  idecoder u_dec (
    .instr  (dec_instr),
    .opcode (dec_opcode),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .rd     (dec_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: pop and compare on issue, push on accepted fetch.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (iif.valid && iif.ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_issue: got instr %08h pc %08h, want no issue", iif.instr, iif.pc);
        end else begin
          e = sb_q.pop_front();
          if (iif.instr !== e.instr || iif.pc !== e.pc || issue_illegal !== e.illegal) begin
            errors++;
            $display("FAIL sb_issue: got instr %08h pc %08h illegal %0b, want instr %08h pc %08h illegal %0b",
                     iif.instr, iif.pc, issue_illegal, e.instr, e.pc, e.illegal);
          end
        end
      end
      if (fif.valid && fif.ready) begin
        e.instr   = fif.instr;
        e.pc      = fif.pc;
        e.illegal = (fif.instr[1:0] != 2'b11);
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, want normal end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fif.valid = 1'b0; fif.instr = 32'd0; fif.pc = 32'd0;
    iif.ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL rst_instr_ready: got %0b want 1", fif.ready); end
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %0b want 0", iif.valid); end
    checks++; if (issue_illegal !== 1'b0) begin errors++; $display("FAIL rst_issue_illegal: got %0b want 0", issue_illegal); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
    checks++; if (dec_instr !== 32'd0) begin errors++; $display("FAIL rst_dec_instr: got %08h want 0", dec_instr); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    tick();
  endtask

  task automatic test_issue();
    fif.valid = 1'b1; fif.instr = 32'h0050_0093; fif.pc = 32'h0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL iss_latency: got valid %0b want 0", iif.valid); end
    tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL iss_valid: got %0b want 1", iif.valid); end
    checks++; if (iif.pc !== 32'h0) begin errors++; $display("FAIL iss_pc: got %08h want 0", iif.pc); end
    tick();
  endtask

  task automatic test_hazard();
    fif.valid = 1'b1; fif.instr = 32'h0010_8133; fif.pc = 32'h4;
    @(negedge clk); tick(); fif.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL hz_raw_block[%0d]: got %0b want 0", i, iif.valid); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd1;
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL hz_stall_cnt3: got %0d want 3", stall_cnt); end
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL hz_wb_cycle: got %0b want 0", iif.valid); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL hz_after_wb: got %0b want 1", iif.valid); end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL hz_stall_cnt4: got %0d want 4", stall_cnt); end
    tick();
    // addi x9,x2,0 must wait for the add's pending x2
    fif.valid = 1'b1; fif.instr = 32'h0001_0493; fif.pc = 32'h8;
    @(negedge clk); tick(); fif.valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL hz_pend2: got %0b want 0", iif.valid); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL hz_pend2_clear: got %0b want 1", iif.valid); end
    tick();
    exp_stall = 5;
  endtask

  task automatic test_full();
    logic [31:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 32'h0000_0513 + (32'h80 * i);
    iif.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fif.valid = 1'b1; fif.instr = w[i]; fif.pc = 32'h40 + 32'(4 * i);
      @(negedge clk);
      checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d]: got %0b want 1", i, fif.ready); end
      tick();
    end
    fif.instr = w[4]; fif.pc = 32'h50;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", fif.ready); end
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL full_head_valid: got %0b want 1", iif.valid); end
    tick();
    @(negedge clk);
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL full_backpressure_stall: got %0d want %0d", stall_cnt, exp_stall); end
    tick(); iif.ready = 1'b1;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru: got %0b want 0", fif.ready); end
    tick();
    @(negedge clk);
    checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %0b want 1", fif.ready); end
    tick(); iif.ready = 1'b0; fif.instr = w[5]; fif.pc = 32'h54;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_count: got %0b want 1", fif.ready); end
    tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b0) begin errors++; $display("FAIL full_refill: got %0b want 0", fif.ready); end
    tick(); iif.ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %0b want 0", iif.valid); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL full_sb_left: got %0d want 0", sb_q.size()); end
    tick();
  endtask

  task automatic test_halt();
    fif.valid = 1'b1; fif.instr = 32'h0; fif.pc = 32'h100;
    @(negedge clk); tick();
    fif.instr = 32'h0000_0A13; fif.pc = 32'h104;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL halt_issue_valid: got %0b want 1", iif.valid); end
    checks++; if (issue_illegal !== 1'b1) begin errors++; $display("FAIL halt_illegal: got %0b want 1", issue_illegal); end
    tick(); fif.instr = 32'h0000_0C93; fif.pc = 32'h108;
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %0b want 1", halted); end
    checks++; if (fif.ready !== 1'b0) begin errors++; $display("FAIL halt_refuse: got %0b want 0", fif.ready); end
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL halt_no_issue: got %0b want 0", iif.valid); end
    checks++; if (dec_instr !== 32'h0000_0A13) begin errors++; $display("FAIL halt_head: got %08h want 00000a13", dec_instr); end
    tick(); fif.valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++; if (fif.ready !== 1'b0) begin errors++; $display("FAIL halt_flush_ready: got %0b want 0", fif.ready); end
    tick(); flush = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got %0b want 0", halted); end
    checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL halt_ready_back: got %0b want 1", fif.ready); end
    checks++; if (dec_instr !== 32'd0) begin errors++; $display("FAIL halt_empty: got %08h want 0", dec_instr); end
    tick();
  endtask

  task automatic test_flush();
    fif.valid = 1'b1; fif.instr = 32'h0010_0293; fif.pc = 32'h200;
    @(negedge clk); tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL fl_x5_issue: got %0b want 1", iif.valid); end
    tick(); iif.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fif.valid = 1'b1; fif.instr = 32'h0000_0A93 + (32'h80 * i); fif.pc = 32'h204 + 32'(4 * i);
      @(negedge clk); tick();
    end
    fif.instr = 32'h0000_0C13; fif.pc = 32'h210; flush = 1'b1;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL fl_no_issue: got %0b want 0", iif.valid); end
    tick(); flush = 1'b0; fif.valid = 1'b0; iif.ready = 1'b1;
    @(negedge clk);
    checks++; if (dec_instr !== 32'd0) begin errors++; $display("FAIL fl_empty: got %08h want 0", dec_instr); end
    checks++; if (fif.ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %0b want 1", fif.ready); end
    tick(); fif.valid = 1'b1; fif.instr = 32'h0002_8313; fif.pc = 32'h220;
    @(negedge clk); tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL fl_pend5_kept: got %0b want 0", iif.valid); end
    checks++; if (dec_instr !== 32'h0002_8313) begin errors++; $display("FAIL fl_head: got %08h want 00028313", dec_instr); end
    tick(); wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clk); tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL fl_pend5_clear: got %0b want 1", iif.valid); end
    tick();
  endtask

  task automatic test_set_wins();
    fif.valid = 1'b1; fif.instr = 32'h0000_11B7; fif.pc = 32'h300;
    @(negedge clk); tick(); fif.valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL sw_lui_issue: got %0b want 1", iif.valid); end
    tick(); wb_valid = 1'b0; fif.valid = 1'b1; fif.instr = 32'h0001_8393; fif.pc = 32'h304;
    @(negedge clk); tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL sw_pend3_set: got %0b want 0", iif.valid); end
    tick(); wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL sw_pend3_clear: got %0b want 1", iif.valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    iif.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fif.valid = 1'b1; fif.instr = 32'h0000_0D13 + (32'h80 * i); fif.pc = 32'h400 + 32'(4 * i);
      @(negedge clk); tick();
    end
    fif.valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %0b want 0", iif.valid); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mrst_stall: got %0d want 0", stall_cnt); end
    checks++; if (dec_instr !== 32'd0) begin errors++; $display("FAIL mrst_empty: got %08h want 0", dec_instr); end
    tick(); iif.ready = 1'b1; fif.valid = 1'b1; fif.instr = 32'h0005_0413; fif.pc = 32'h500;
    @(negedge clk); tick(); fif.valid = 1'b0;
    @(negedge clk);
    checks++; if (iif.valid !== 1'b1) begin errors++; $display("FAIL mrst_pend_cleared: got %0b want 1", iif.valid); end
    tick();
    @(negedge clk);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL end_sb_left: got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_hazard();
    test_full();
    test_halt();
    test_flush();
    test_set_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
